tdm_demux_1x4: RTL

- Receive end of a 4-channel time-division link: accepts one serialized word per valid cycle, tracks the slot position using a frame-sync marker, and routes each word to its channel.
- Partial frames are held in shadow registers; all four channel outputs update together when a frame completes.
- Sits downstream of the 4:1 channel multiplexer that serializes i0..i3 onto the shared link.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_demux_1x4_sat_counter.sv | 34 +++
 rtl/tdm_demux_1x4.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared encodings and sizes for the 4-slot TDM receive path.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux_1x4_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive side of a 4-channel TDM link: locks on frame_sync, collects slots in
// shadow registers and publishes all four channel words together per frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_HUNT    | no frame alignment; non-sync words are dropped silently
// ST_LOCKED  | aligned; slot_q is the index of the next expected word
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [WIDTH-1:0]  y0,
    output logic [WIDTH-1:0]  y1,
    output logic [WIDTH-1:0]  y2,
    output logic [WIDTH-1:0]  y3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    tdm_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WIDTH-1:0]  shadow0_q, shadow0_d;
    logic [WIDTH-1:0]  shadow1_q, shadow1_d;
    logic [WIDTH-1:0]  shadow2_q, shadow2_d;
    logic [WIDTH-1:0]  y0_q, y0_d;
    logic [WIDTH-1:0]  y1_q, y1_d;
    logic [WIDTH-1:0]  y2_q, y2_d;
    logic [WIDTH-1:0]  y3_q, y3_d;
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        y3_d          = y3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        shadow0_d = din;
                        slot_d    = SLOT_W'(1);
                        state_d   = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_sync) begin
                        // An early sync drops the partial frame and restarts at slot 0.
                        sync_err_d = (slot_q != '0);
                        shadow0_d  = din;
                        slot_d     = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = ST_HUNT;
                    end else if (slot_q == LAST_SLOT) begin
                        y0_d          = shadow0_q;
                        y1_d          = shadow1_q;
                        y2_d          = shadow2_q;
                        y3_d          = din;
                        slot_d        = '0;
                        frame_valid_d = 1'b1;
                    end else begin
                        if (slot_q == SLOT_W'(1)) begin
                            shadow1_d = din;
                        end else begin
                            shadow2_d = din;
                        end
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            slot_q        <= '0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            y3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            y0_q          <= y0_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            y3_q          <= y3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Counting the next-state pulse keeps err_cnt in step with sync_err.
    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (sync_err_d),
        .clear(1'b0),
        .count(err_cnt)
    );

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = sync_err_q;

endmodule
